// File: rtl/accelerator_tensor_transmitter.sv
// rtl/accelerator_tensor_transmitter.sv - streams an I x J x K tensor from a read buffer, one element per handshake
module accelerator_tensor_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 ADVANCE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] LENGTH_IN,
    output logic                 READ_ENABLE,
    output logic [DATA_SIZE-1:0] ADDRESS_OUT,
    input  logic [DATA_SIZE-1:0] READ_DATA_IN,
    output logic                 DATA_OUT_MATRIX_ENABLE,
    output logic                 DATA_OUT_VECTOR_ENABLE,
    output logic                 DATA_OUT_SCALAR_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        EMIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_SIZE-1:0]    size_i;
    logic [DATA_SIZE-1:0]    size_j;
    logic [DATA_SIZE-1:0]    size_k;
    logic                    size_zero;
    logic [CONTROL_SIZE-1:0] idx_i;
    logic [CONTROL_SIZE-1:0] idx_j;
    logic [CONTROL_SIZE-1:0] idx_k;
    logic [DATA_SIZE-1:0]    addr;

    logic i_last;
    logic j_last;
    logic k_last;

    assign i_last = (idx_i == CONTROL_SIZE'(size_i - DATA_SIZE'(1)));
    assign j_last = (idx_j == CONTROL_SIZE'(size_j - DATA_SIZE'(1)));
    assign k_last = (idx_k == CONTROL_SIZE'(size_k - DATA_SIZE'(1)));

    // An empty tensor still passes through READ (with the strobe suppressed)
    // so the zero-size decision is made on the latched sizes, not the live inputs.
    assign READ_ENABLE = (state == READ) && !size_zero;
    assign READY       = (state == DONE);
    assign ADDRESS_OUT = addr;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = size_zero ? DONE : LOAD;
            end
            LOAD: begin
                state_next = EMIT;
            end
            EMIT: begin
                if (ADVANCE) begin
                    state_next = (i_last && j_last && k_last) ? DONE : READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state                  <= IDLE;
            size_i                 <= '0;
            size_j                 <= '0;
            size_k                 <= '0;
            size_zero              <= 1'b0;
            idx_i                  <= '0;
            idx_j                  <= '0;
            idx_k                  <= '0;
            addr                   <= '0;
            DATA_OUT               <= '0;
            DATA_OUT_MATRIX_ENABLE <= 1'b0;
            DATA_OUT_VECTOR_ENABLE <= 1'b0;
            DATA_OUT_SCALAR_ENABLE <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (START) begin
                        size_i    <= SIZE_I_IN;
                        size_j    <= SIZE_J_IN;
                        size_k    <= LENGTH_IN;
                        size_zero <= (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (LENGTH_IN == '0);
                        idx_i     <= '0;
                        idx_j     <= '0;
                        idx_k     <= '0;
                        addr      <= '0;
                    end
                end
                LOAD: begin
                    DATA_OUT               <= READ_DATA_IN;
                    DATA_OUT_SCALAR_ENABLE <= 1'b1;
                    DATA_OUT_VECTOR_ENABLE <= (idx_k == '0);
                    DATA_OUT_MATRIX_ENABLE <= (idx_j == '0) && (idx_k == '0);
                end
                EMIT: begin
                    if (ADVANCE) begin
                        DATA_OUT_SCALAR_ENABLE <= 1'b0;
                        DATA_OUT_VECTOR_ENABLE <= 1'b0;
                        DATA_OUT_MATRIX_ENABLE <= 1'b0;
                        // k-fastest order makes the linear address a plain counter
                        addr <= addr + DATA_SIZE'(1);
                        if (k_last) begin
                            idx_k <= '0;
                            if (j_last) begin
                                idx_j <= '0;
                                idx_i <= idx_i + CONTROL_SIZE'(1);
                            end else begin
                                idx_j <= idx_j + CONTROL_SIZE'(1);
                            end
                        end else begin
                            idx_k <= idx_k + CONTROL_SIZE'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_tensor_transmitter.sv
// tb/tb_accelerator_tensor_transmitter.sv - scoreboard bench for accelerator_tensor_transmitter
module tb_accelerator_tensor_transmitter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        advance;
    logic [63:0] size_i;
    logic [63:0] size_j;
    logic [63:0] length;
    logic        read_enable;
    logic [63:0] address;
    logic [63:0] read_data;
    logic        m_en;
    logic        v_en;
    logic        s_en;
    logic [63:0] data_out;

    accelerator_tensor_transmitter dut (
        .CLK                    (clk),
        .RST                    (rst_n),
        .START                  (start),
        .READY                  (ready),
        .ADVANCE                (advance),
        .SIZE_I_IN              (size_i),
        .SIZE_J_IN              (size_j),
        .LENGTH_IN              (length),
        .READ_ENABLE            (read_enable),
        .ADDRESS_OUT            (address),
        .READ_DATA_IN           (read_data),
        .DATA_OUT_MATRIX_ENABLE (m_en),
        .DATA_OUT_VECTOR_ENABLE (v_en),
        .DATA_OUT_SCALAR_ENABLE (s_en),
        .DATA_OUT               (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: mem[a] = a + 100, one cycle read latency
    always @(posedge clk) begin
        if (read_enable) read_data <= address + 64'd100;
        else             read_data <= 64'hDEAD_BEEF;
    end

    typedef struct {
        logic [63:0] d;
        logic        m;
        logic        v;
        logic        s;
    } elem_t;

    elem_t exp_q[$];
    int    ready_q[$];
    int    checks;
    int    failures;
    int    cyc;
    int    start_cyc;
    logic  no_read;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an element or READY
    logic        prev_s;
    logic        prev_m;
    logic        prev_v;
    logic [63:0] prev_d;
    initial begin
        prev_s = 0; prev_m = 0; prev_v = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            if (s_en && !prev_s) begin
                if (exp_q.size() == 0) begin
                    chk("elem_unexpected", 64'(s_en), 64'd0);
                end else begin
                    elem_t e;
                    e = exp_q.pop_front();
                    chk("elem_data", data_out, e.d);
                    chk("elem_matrix", 64'(m_en), 64'(e.m));
                    chk("elem_vector", 64'(v_en), 64'(e.v));
                    chk("elem_scalar", 64'(s_en), 64'(e.s));
                end
            end else if (s_en && prev_s) begin
                chk("hold_data", data_out, prev_d);
                chk("hold_strobes", {62'd0, m_en, v_en}, {62'd0, prev_m, prev_v});
            end
            if (ready) begin
                if (ready_q.size() == 0) chk("ready_unexpected", 64'(ready), 64'd0);
                else chk("ready_cycle", 64'(cyc - start_cyc), 64'(ready_q.pop_front()));
            end
            if (no_read) chk("no_read_enable", 64'(read_enable), 64'd0);
            prev_s = s_en; prev_m = m_en; prev_v = v_en; prev_d = data_out;
        end
    end

    task automatic push_elem(input logic [63:0] d, input logic m, input logic v);
        elem_t e;
        e.d = d; e.m = m; e.v = v; e.s = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic start_xfer(input logic [63:0] i, input logic [63:0] j, input logic [63:0] k);
        @(negedge clk);
        size_i = i; size_j = j; length = k;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ready_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_elems", 64'(exp_q.size()), 64'd0);
        chk("drain_ready", 64'(ready_q.size()), 64'd0);
        exp_q.delete();
        ready_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_elem(input logic [63:0] d, output bit found);
        int n;
        n = 0;
        found = 0;
        while (n < 100 && !found) begin
            @(negedge clk);
            if (s_en && data_out == d) found = 1;
            n++;
        end
        if (!found) chk("wait_elem_timeout", d, 64'd0);
    endtask

    logic [7:0] m_tab;
    logic [7:0] v_tab;
    bit         found;

    initial begin
        checks = 0; failures = 0; cyc = 0; start_cyc = 0; no_read = 0;
        rst_n = 1'b0; start = 1'b0; advance = 1'b1;
        size_i = '0; size_j = '0; length = '0;
        m_tab = 8'b0001_0001;
        v_tab = 8'b0101_0101;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_read_enable", 64'(read_enable), 64'd0);
        chk("rst_address", address, 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_strobes", {61'd0, m_en, v_en, s_en}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2x2 streaming with ADVANCE held high
        for (int e = 0; e < 8; e++) push_elem(64'd100 + 64'(e), m_tab[e], v_tab[e]);
        ready_q.push_back(25);
        start_xfer(2, 2, 2);
        drain(100);

        // Backpressure on element 3 for 5 cycles
        for (int e = 0; e < 8; e++) push_elem(64'd100 + 64'(e), m_tab[e], v_tab[e]);
        ready_q.push_back(30);
        start_xfer(2, 2, 2);
        wait_elem(64'd103, found);
        if (found) begin
            advance = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("bp_data", data_out, 64'd103);
                chk("bp_read_enable", 64'(read_enable), 64'd0);
                chk("bp_scalar", 64'(s_en), 64'd1);
            end
            advance = 1'b1;
        end
        drain(100);

        // Zero length: no reads, no elements, READY in cycle 2
        ready_q.push_back(2);
        no_read = 1'b1;
        start_xfer(3, 2, 0);
        drain(20);
        no_read = 1'b0;

        // START pulsed mid-transfer is ignored
        push_elem(64'd100, 1'b1, 1'b1);
        push_elem(64'd101, 1'b0, 1'b0);
        push_elem(64'd102, 1'b0, 1'b0);
        ready_q.push_back(10);
        start_xfer(1, 1, 3);
        wait_elem(64'd101, found);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(60);

        // Reset during element 2, then a fresh 1x1x1 transfer
        push_elem(64'd100, 1'b1, 1'b1);
        push_elem(64'd101, 1'b0, 1'b0);
        push_elem(64'd102, 1'b0, 1'b1);
        start_xfer(2, 2, 2);
        wait_elem(64'd102, found);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'd0);
        chk("mid_rst_read_enable", 64'(read_enable), 64'd0);
        chk("mid_rst_address", address, 64'd0);
        chk("mid_rst_data", data_out, 64'd0);
        chk("mid_rst_strobes", {61'd0, m_en, v_en, s_en}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain(5);
        push_elem(64'd100, 1'b1, 1'b1);
        ready_q.push_back(4);
        start_xfer(1, 1, 1);
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
